// File: rtl/kmi_link_sequencer_if.sv
// Handshake bundle between the KMI link sequencer and the Rx/Tx engines
// and APB slave. The sequencer owns the master modport.
interface kmi_link_sequencer_if;
  logic       tx_req;
  logic       tx_ack;
  logic       rx_start;
  logic       rx_done;
  logic       tx_done;
  logic       rx_en;
  logic       rx_abort;
  logic       tx_go;
  logic       tx_abort;
  logic       clk_inhibit;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;
  logic [2:0] state_dbg;

  modport master (
    input  tx_req, rx_start, rx_done, tx_done, err_clr,
    output tx_ack, rx_en, rx_abort, tx_go, tx_abort, clk_inhibit,
           busy, timeout_err, state_dbg
  );

  modport slave (
    output tx_req, rx_start, rx_done, tx_done, err_clr,
    input  tx_ack, rx_en, rx_abort, tx_go, tx_abort, clk_inhibit,
           busy, timeout_err, state_dbg
  );
endinterface

// File: rtl/kmi_link_sequencer.sv
// Half-duplex KMI line owner: arbitrates device receive against host
// transmit (with clock inhibit), watchdogs each frame, reports status.
module kmi_link_sequencer #(
  parameter int INHIBIT_CYCLES = 800,
  parameter int TIMEOUT_CYCLES = 16000,
  parameter int CNT_W          = 16
) (
  input  logic                  ref_clk,
  input  logic                  reset,
  kmi_link_sequencer_if.master  link
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX      = 2'd1,
    INHIBIT = 2'd2,
    TX      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tx_ack_q;
  logic             tx_go_q;
  logic             rx_abort_q;
  logic             tx_abort_q;
  logic             timeout_err_q;
  logic             timeout_hit;

  // A pending done pulse beats the watchdog in the same cycle.
  always_comb begin
    timeout_hit = 1'b0;
    if (cnt == TIMEOUT_LAST) begin
      if (state == RX && !link.rx_done)
        timeout_hit = 1'b1;
      else if (state == TX && !link.tx_done)
        timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      tx_ack_q      <= 1'b0;
      tx_go_q       <= 1'b0;
      rx_abort_q    <= 1'b0;
      tx_abort_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      tx_ack_q      <= 1'b0;
      tx_go_q       <= 1'b0;
      rx_abort_q    <= 1'b0;
      tx_abort_q    <= 1'b0;
      timeout_err_q <= timeout_hit | (timeout_err_q & ~link.err_clr);
      cnt           <= cnt + 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (link.rx_start) begin
            state <= RX;
          end else if (link.tx_req) begin
            state    <= INHIBIT;
            tx_ack_q <= 1'b1;
          end
        end

        RX: begin
          if (link.rx_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (timeout_hit) begin
            state      <= IDLE;
            cnt        <= '0;
            rx_abort_q <= 1'b1;
          end
        end

        INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            state   <= TX;
            cnt     <= '0;
            tx_go_q <= 1'b1;
          end
        end

        TX: begin
          if (link.tx_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (timeout_hit) begin
            state      <= IDLE;
            cnt        <= '0;
            tx_abort_q <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Line-level outputs decode straight from the state register so that
  // reset releases the KMI clock without waiting for an edge.
  assign link.rx_en       = (state == IDLE) || (state == RX);
  assign link.clk_inhibit = (state == INHIBIT);
  assign link.busy        = (state != IDLE);
  assign link.state_dbg   = {1'b0, state};
  assign link.tx_ack      = tx_ack_q;
  assign link.tx_go       = tx_go_q;
  assign link.rx_abort    = rx_abort_q;
  assign link.tx_abort    = tx_abort_q;
  assign link.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_kmi_link_sequencer.sv
// Directed bench for kmi_link_sequencer (INHIBIT_CYCLES=4, TIMEOUT_CYCLES=20).
module tb_kmi_link_sequencer;

  logic ref_clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  kmi_link_sequencer_if link ();

  kmi_link_sequencer #(
    .INHIBIT_CYCLES (4),
    .TIMEOUT_CYCLES (20),
    .CNT_W          (8)
  ) dut (
    .ref_clk (ref_clk),
    .reset   (reset),
    .link    (link)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // state, tx_ack, tx_go, clk_inhibit, rx_en, busy
  task automatic chk_state(input string tag, input logic [2:0] st, input logic ack,
                           input logic go, input logic inh, input logic ren, input logic bsy);
    chk({tag, ".state"}, 16'(link.state_dbg), 16'(st));
    chk({tag, ".tx_ack"}, 16'(link.tx_ack), 16'(ack));
    chk({tag, ".tx_go"}, 16'(link.tx_go), 16'(go));
    chk({tag, ".clk_inhibit"}, 16'(link.clk_inhibit), 16'(inh));
    chk({tag, ".rx_en"}, 16'(link.rx_en), 16'(ren));
    chk({tag, ".busy"}, 16'(link.busy), 16'(bsy));
  endtask

  task automatic chk_err(input string tag, input logic rab, input logic tab, input logic terr);
    chk({tag, ".rx_abort"}, 16'(link.rx_abort), 16'(rab));
    chk({tag, ".tx_abort"}, 16'(link.tx_abort), 16'(tab));
    chk({tag, ".timeout_err"}, 16'(link.timeout_err), 16'(terr));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset          = 1'b1;
    link.tx_req    = 1'b0;
    link.rx_start  = 1'b0;
    link.rx_done   = 1'b0;
    link.tx_done   = 1'b0;
    link.err_clr   = 1'b0;

    // 1. reset state
    tick(); tick();
    chk_state("rst", 3'd0, 0, 0, 0, 1, 0);
    chk_err("rst", 0, 0, 0);
    reset = 1'b0;
    tick(); tick();
    chk_state("idle", 3'd0, 0, 0, 0, 1, 0);

    // 2. host transmit with inhibit, rx_done/rx_start ignored during inhibit
    link.tx_req = 1'b1;
    tick();
    chk_state("inh0", 3'd2, 1, 0, 1, 0, 1);
    link.tx_req  = 1'b0;
    link.rx_done = 1'b1;
    link.rx_start = 1'b1;
    tick();
    chk_state("inh1", 3'd2, 0, 0, 1, 0, 1);
    link.rx_done  = 1'b0;
    link.rx_start = 1'b0;
    tick();
    chk_state("inh2", 3'd2, 0, 0, 1, 0, 1);
    tick();
    chk_state("inh3", 3'd2, 0, 0, 1, 0, 1);
    tick();
    chk_state("tx0", 3'd3, 0, 1, 0, 0, 1);
    tick();
    chk_state("tx1", 3'd3, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    chk_state("tx6", 3'd3, 0, 0, 0, 0, 1);
    link.tx_done = 1'b1;
    tick();
    link.tx_done = 1'b0;
    chk_state("txdone", 3'd0, 0, 0, 0, 1, 0);
    chk_err("txdone", 0, 0, 0);

    // 1b. asynchronous reset mid-inhibit
    link.tx_req = 1'b1;
    tick();
    link.tx_req = 1'b0;
    tick();
    chk_state("inh_pre_rst", 3'd2, 0, 0, 1, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_state("async_rst", 3'd0, 0, 0, 0, 1, 0);
    chk_err("async_rst", 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_state("post_rst", 3'd0, 0, 0, 0, 1, 0);

    // 3. rx_start beats tx_req; pending tx serviced after rx_done
    link.rx_start = 1'b1;
    link.tx_req   = 1'b1;
    tick();
    link.rx_start = 1'b0;
    chk_state("rx0", 3'd1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) tick();
    chk_state("rx5", 3'd1, 0, 0, 0, 1, 1);
    link.rx_done = 1'b1;
    tick();
    link.rx_done = 1'b0;
    chk_state("rxdone", 3'd0, 0, 0, 0, 1, 0);
    tick();
    chk_state("b2b_inh", 3'd2, 1, 0, 1, 0, 1);
    link.tx_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_state("b2b_inh3", 3'd2, 0, 0, 1, 0, 1);
    tick();
    chk_state("b2b_tx", 3'd3, 0, 1, 0, 0, 1);
    link.tx_done = 1'b1;
    tick();
    link.tx_done = 1'b0;
    chk_state("b2b_done", 3'd0, 0, 0, 0, 1, 0);

    // 4. RX watchdog timeout, then err_clr; stray tx_done ignored in RX
    link.rx_start = 1'b1;
    tick();
    link.rx_start = 1'b0;
    link.tx_done  = 1'b1;
    tick();
    link.tx_done  = 1'b0;
    chk_state("rxto1", 3'd1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 18; i++) tick();
    chk_state("rxto19", 3'd1, 0, 0, 0, 1, 1);
    chk_err("rxto19", 0, 0, 0);
    tick();
    chk_state("rxto_idle", 3'd0, 0, 0, 0, 1, 0);
    chk_err("rxto_idle", 1, 0, 1);
    tick();
    chk_err("rxto_hold", 0, 0, 1);
    link.err_clr = 1'b1;
    tick();
    link.err_clr = 1'b0;
    chk_err("errclr", 0, 0, 0);

    // 5. tx_done coincident with TX timeout compare: done wins
    link.tx_req = 1'b1;
    tick();
    link.tx_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_state("to5_tx0", 3'd3, 0, 1, 0, 0, 1);
    for (int i = 0; i < 19; i++) tick();
    chk_state("to5_tx19", 3'd3, 0, 0, 0, 0, 1);
    link.tx_done = 1'b1;
    tick();
    link.tx_done = 1'b0;
    chk_state("to5_idle", 3'd0, 0, 0, 0, 1, 0);
    chk_err("to5_idle", 0, 0, 0);

    // 6. TX timeout with err_clr in the same cycle: set wins
    link.tx_req = 1'b1;
    tick();
    link.tx_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_state("to6_tx0", 3'd3, 0, 1, 0, 0, 1);
    for (int i = 0; i < 19; i++) tick();
    link.err_clr = 1'b1;
    tick();
    link.err_clr = 1'b0;
    chk_state("to6_idle", 3'd0, 0, 0, 0, 1, 0);
    chk_err("to6_idle", 0, 1, 1);
    tick();
    chk_err("to6_hold", 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
